counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_if.sv | 10 +
 rtl/counter_ctrl.sv | 116 +++++++++++
 tb/tb_counter_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// Command handshake bundle for counter_ctrl: valid/ready plus op and data.
interface counter_ctrl_if;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic [1:0] cmd_op_in;
  logic [7:0] cmd_data_in;

  modport master (output cmd_valid_in, cmd_op_in, cmd_data_in, input cmd_ready_out);
  modport slave  (input cmd_valid_in, cmd_op_in, cmd_data_in, output cmd_ready_out);
endinterface

// File: rtl/counter_ctrl.sv
// Sequences LOAD/UP/DOWN/HOLD commands onto an external 8-bit counter and tracks its expected value.
// Optional macro CNT_CTRL_CHECK_EN: compare observed counter against expected in CHECK, sticky err_out.
module counter_ctrl (
  input  logic           clk_in,
  input  logic           nrst_in,
  counter_ctrl_if.slave  cmd,
  output logic           en_ctrl_out,
  output logic           set_ctrl_out,
  output logic           up_ctrl_out,
  output logic [7:0]     counter_val_out,
  input  logic [7:0]     counter_obs_in,
  input  logic           ovf_in,
  output logic           busy_out,
  output logic           done_out,
  output logic [7:0]     result_out,
  output logic           wrap_out,
  output logic           err_out
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_UP   = 2'd1;
  localparam logic [1:0] OP_DOWN = 2'd2;

  logic [2:0] state;
  logic [1:0] op_q;
  logic [7:0] cnt_q;
  logic [7:0] exp_q;
  logic       wrap_q;
  logic       accept;
  logic       run_en;

  assign cmd.cmd_ready_out = (state == S_IDLE) && nrst_in;
  assign accept            = cmd.cmd_valid_in && cmd.cmd_ready_out;
  assign run_en            = (state == S_RUN) && ((op_q == OP_UP) || (op_q == OP_DOWN));

  assign en_ctrl_out  = run_en;
  assign up_ctrl_out  = run_en && (op_q == OP_UP);
  assign set_ctrl_out = (state == S_LOAD);
  assign busy_out     = (state != S_IDLE);
  assign done_out     = (state == S_DONE);
  assign wrap_out     = wrap_q;

`ifdef CNT_CTRL_CHECK_EN
  logic err_q;
  logic mismatch;
  assign mismatch = (counter_obs_in != exp_q) || (ovf_in != (exp_q == 8'hFF));
  assign err_out  = err_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_in;
  assign err_out    = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state           <= S_IDLE;
      op_q            <= 2'd0;
      cnt_q           <= 8'd0;
      exp_q           <= 8'd0;
      counter_val_out <= 8'd0;
      result_out      <= 8'd0;
`ifdef CNT_CTRL_CHECK_EN
      err_q           <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q  <= cmd.cmd_op_in;
          cnt_q <= cmd.cmd_data_in;
          if (cmd.cmd_op_in == OP_LOAD) begin
            // Load value is registered here so it holds after the LOAD cycle.
            counter_val_out <= cmd.cmd_data_in;
            state           <= S_LOAD;
          end else if (cmd.cmd_data_in == 8'd0) begin
            state <= S_CHECK;
          end else begin
            state <= S_RUN;
          end
        end
        S_LOAD: begin
          exp_q <= counter_val_out;
          state <= S_CHECK;
        end
        S_RUN: begin
          if (run_en) exp_q <= (op_q == OP_UP) ? exp_q + 8'd1 : exp_q - 8'd1;
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) state <= S_CHECK;
        end
        S_CHECK: begin
          result_out <= counter_obs_in;
`ifdef CNT_CTRL_CHECK_EN
          if (mismatch) begin
            err_q <= 1'b1;
            exp_q <= counter_obs_in;
          end
`endif
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pulse lands in the cycle after the wrapping exp update.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) wrap_q <= 1'b0;
    else          wrap_q <= run_en && (((op_q == OP_UP) && (exp_q == 8'hFF)) ||
                                       ((op_q == OP_DOWN) && (exp_q == 8'h00)));
  end
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural counter that can drop one increment.
module tb_counter_ctrl;
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_UP   = 2'd1;
  localparam logic [1:0] OP_DOWN = 2'd2;
  localparam logic [1:0] OP_HOLD = 2'd3;
`ifdef CNT_CTRL_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] res;
    int         wraps;
    int         sets;
    int         ens;
    int         lat;
  } vec_t;

  logic       clk_in = 1'b0;
  logic       nrst_in = 1'b0;
  logic       en_ctrl_out, set_ctrl_out, up_ctrl_out;
  logic [7:0] counter_val_out, result_out;
  logic [7:0] cnt_model;
  logic       busy_out, done_out, wrap_out, err_out;
  int         en_cnt;
  int         skip_idx = -1;
  int         total = 0;
  int         bad = 0;

  counter_ctrl_if cif ();

  counter_ctrl dut (
    .clk_in          (clk_in),
    .nrst_in         (nrst_in),
    .cmd             (cif.slave),
    .en_ctrl_out     (en_ctrl_out),
    .set_ctrl_out    (set_ctrl_out),
    .up_ctrl_out     (up_ctrl_out),
    .counter_val_out (counter_val_out),
    .counter_obs_in  (cnt_model),
    .ovf_in          (cnt_model == 8'hFF),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .result_out      (result_out),
    .wrap_out        (wrap_out),
    .err_out         (err_out)
  );

  always #5 clk_in = ~clk_in;

  // Counter model; en pulse number skip_idx is dropped to emulate a faulty counter.
  always @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      cnt_model <= 8'd0;
      en_cnt    <= 0;
    end else if (set_ctrl_out) begin
      cnt_model <= counter_val_out;
    end else if (en_ctrl_out) begin
      en_cnt <= en_cnt + 1;
      if (en_cnt != skip_idx) cnt_model <= up_ctrl_out ? cnt_model + 8'd1 : cnt_model - 8'd1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command from a negedge and observe until done_out; keep_valid holds a bogus LOAD 77 on the bus while busy.
  task automatic run_cmd(input vec_t v, input int exp_err, input bit keep_valid);
    int i, setc, enc, upc, wc, lat, rdy_busy;
    logic [7:0] setval;
    i = 0;
    while (!cif.cmd_ready_out && i < 20) begin @(negedge clk_in); i++; end
    chk("ready_before_cmd", cif.cmd_ready_out, 1);
    cif.cmd_valid_in = 1'b1;
    cif.cmd_op_in    = v.op;
    cif.cmd_data_in  = v.data;
    @(posedge clk_in);
    #1;
    if (keep_valid) begin
      cif.cmd_op_in   = OP_LOAD;
      cif.cmd_data_in = 8'h77;
    end else begin
      cif.cmd_valid_in = 1'b0;
    end
    setc = 0; enc = 0; upc = 0; wc = 0; lat = -1; rdy_busy = 0; setval = 8'h00;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk_in);
      if (set_ctrl_out) begin setc++; setval = counter_val_out; end
      if (en_ctrl_out) enc++;
      if (up_ctrl_out) upc++;
      if (wrap_out) wc++;
      if (busy_out && cif.cmd_ready_out) rdy_busy++;
      if (done_out) begin lat = c; break; end
    end
    cif.cmd_valid_in = 1'b0;
    chk("done_latency", lat, v.lat);
    chk("result_out", result_out, v.res);
    chk("wrap_pulses", wc, v.wraps);
    chk("set_cycles", setc, v.sets);
    chk("en_cycles", enc, v.ens);
    chk("up_cycles", upc, (v.op == OP_UP) ? v.ens : 0);
    chk("err_out", err_out, exp_err);
    chk("ready_while_busy", rdy_busy, 0);
    if (v.op == OP_LOAD) chk("load_value", setval, v.data);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    nrst_in = 1'b0;
    @(negedge clk_in);
    nrst_in = 1'b1;
  endtask

  vec_t tbl[8];
  vec_t v;
  int   dn;

  initial begin
    cif.cmd_valid_in = 1'b0;
    cif.cmd_op_in    = 2'd0;
    cif.cmd_data_in  = 8'd0;

    //           op       data   res    wraps sets ens lat
    tbl[0] = '{OP_LOAD, 8'h5A, 8'h5A, 0, 1, 0, 3};
    tbl[1] = '{OP_LOAD, 8'hFE, 8'hFE, 0, 1, 0, 3};
    tbl[2] = '{OP_UP,   8'd3,  8'h01, 1, 0, 3, 5};
    tbl[3] = '{OP_HOLD, 8'd0,  8'h01, 0, 0, 0, 2};
    tbl[4] = '{OP_HOLD, 8'd2,  8'h01, 0, 0, 0, 4};
    tbl[5] = '{OP_DOWN, 8'd2,  8'hFF, 1, 0, 2, 4};
    tbl[6] = '{OP_UP,   8'd1,  8'h00, 1, 0, 1, 3};
    tbl[7] = '{OP_LOAD, 8'h00, 8'h00, 0, 1, 0, 3};

    // Reset state
    #12;
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_ctrl", {en_ctrl_out, set_ctrl_out, up_ctrl_out, wrap_out}, 0);
    chk("rst_val", counter_val_out, 0);
    chk("rst_result", result_out, 0);
    chk("rst_err", err_out, 0);
    @(negedge clk_in);
    nrst_in = 1'b1;
    @(negedge clk_in);
    chk("rst_ready", cif.cmd_ready_out, 1);

    for (int k = 0; k < 8; k++) run_cmd(tbl[k], 0, 1'b0);

    // DOWN 1 straight out of reset: 00 -> FF with overflow flag high
    do_reset();
    v = '{OP_DOWN, 8'd1, 8'hFF, 1, 0, 1, 3};
    run_cmd(v, 0, 1'b0);

    // HOLD 3 with valid kept high as a LOAD 77 while busy: must be ignored
    v = '{OP_HOLD, 8'd3, 8'hFF, 0, 0, 0, 5};
    run_cmd(v, 0, 1'b1);
    @(negedge clk_in);
    chk("ignored_load_val", counter_val_out, 8'h00);
    chk("ignored_load_busy", busy_out, 0);

    // Reset in the middle of UP 10
    cif.cmd_valid_in = 1'b1;
    cif.cmd_op_in    = OP_UP;
    cif.cmd_data_in  = 8'd10;
    @(posedge clk_in);
    #1 cif.cmd_valid_in = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("mid_run_en", en_ctrl_out, 1);
    #2 nrst_in = 1'b0;
    #1;
    chk("abort_busy", busy_out, 0);
    chk("abort_en", en_ctrl_out, 0);
    chk("abort_result", result_out, 0);
    chk("abort_val", counter_val_out, 0);
    dn = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clk_in); if (done_out) dn++; end
    nrst_in = 1'b1;
    for (int c = 0; c < 12; c++) begin @(negedge clk_in); if (done_out) dn++; end
    chk("abort_no_done", dn, 0);
    v = '{OP_LOAD, 8'h33, 8'h33, 0, 1, 0, 3};
    run_cmd(v, 0, 1'b0);

    // Faulty counter drops the second increment of UP 4 from 00
    do_reset();
    skip_idx = 1;
    v = '{OP_UP, 8'd4, 8'h03, 0, 0, 4, 6};
    run_cmd(v, CHK, 1'b0);
    skip_idx = -1;
    v = '{OP_LOAD, 8'h10, 8'h10, 0, 1, 0, 3};
    run_cmd(v, CHK, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
